// File: rtl/mutative_types.sv
// Shared types for the mutative cache: address layout and mode encoding.
// Exports cache_address_t, SET_BITS, TAG_BITS, OFFSET_BITS, setup_t, step_toward().
package mutative_types;

    localparam int SET_BITS    = 4;
    localparam int TAG_BITS    = 23;
    localparam int OFFSET_BITS = 32 - TAG_BITS - SET_BITS;

    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [SET_BITS-1:0]    set_index;
        logic [OFFSET_BITS-1:0] offset;
    } cache_address_t;

    typedef enum logic [1:0] {
        DM   = 2'd0,
        WAY2 = 2'd1,
        WAY4 = 2'd2,
        WAY8 = 2'd3
    } setup_t;

    // One mode step from cur toward want (callers guarantee cur != want).
    function automatic logic [1:0] step_toward(
        input logic [1:0] cur,
        input logic [1:0] want
    );
        return (want > cur) ? cur + 2'd1 : cur - 2'd1;
    endfunction

endpackage

// File: rtl/assoc_tag_history.sv
// Per-set {valid, last tag} history used to detect set conflicts.
// Ports: clk, rst, clear (flush valids), set_index/tag (lookup + write), wr_en, conflict.
module assoc_tag_history #(
    parameter int SET_BITS = 4,
    parameter int TAG_BITS = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [SET_BITS-1:0] set_index,
    input  logic [TAG_BITS-1:0] tag,
    input  logic                wr_en,
    output logic                conflict
);
    import mutative_types::*;

    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]     valid_q;
    logic [TAG_BITS-1:0] tag_q [SETS];

    // A differing tag in a valid entry is a conflict; empty entries are not.
    assign conflict = valid_q[set_index] && (tag_q[set_index] != tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[set_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '{default: '0};
        end else if (wr_en) begin
            tag_q[set_index] <= tag;
        end
    end

endmodule

// File: rtl/assoc_mode_advisor.sv
// Epoch-based associativity advisor: counts conflicts/PLRU bias, proposes one mode step.
// Ports: clk, rst, cache_address, cpu_request, cache_ready, setup, plru_bit0, tie,
//        setup_ready in; setup_valid, setup_update out. Optional: ASSOC_TIE_HOLD_EN.
module assoc_mode_advisor #(
    parameter int EPOCH_LEN = 1024,
    parameter int SET_BITS  = mutative_types::SET_BITS,
    parameter int TAG_BITS  = mutative_types::TAG_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  mutative_types::cache_address_t cache_address,
    input  logic                           cpu_request,
    input  logic                           cache_ready,
    input  logic [1:0]                     setup,
    input  logic                           plru_bit0,
    input  logic                           tie,
    input  logic                           setup_ready,
    output logic                           setup_valid,
    output logic [1:0]                     setup_update
);
    import mutative_types::*;

    localparam int OFF_BITS = 32 - TAG_BITS - SET_BITS;
    localparam int CW = $clog2(EPOCH_LEN) + 1;
    localparam int PW = CW + 5;
    localparam logic [CW-1:0] LAST = CW'(EPOCH_LEN - 1);
    localparam logic [PW-1:0] EL   = PW'(EPOCH_LEN);
    localparam logic [PW-1:0] EL3  = PW'(3 * EPOCH_LEN);

    logic [TAG_BITS-1:0] acc_tag;
    logic [SET_BITS-1:0] acc_set;
    logic [OFF_BITS-1:0] unused_offset;

    assign acc_tag       = cache_address[31 -: TAG_BITS];
    assign acc_set       = cache_address[OFF_BITS +: SET_BITS];
    assign unused_offset = cache_address[OFF_BITS-1:0];

    logic [CW-1:0] acc_cnt, conf_cnt, left_cnt;
    logic [CW-1:0] conf_nxt, left_nxt;
    logic          complete, handshake, epoch_end;
    logic          conflict, hold;
    logic [PW-1:0] conf_p, left_p;
    logic [1:0]    desired;

    // Accesses completing while a proposal is pending are not observed.
    assign complete  = cpu_request && cache_ready && !setup_valid;
    assign handshake = setup_valid && setup_ready;
    assign epoch_end = complete && (acc_cnt == LAST);

    assign conf_nxt = conf_cnt + CW'(conflict);
    assign left_nxt = left_cnt + CW'(plru_bit0);
    assign conf_p   = PW'(conf_nxt);
    assign left_p   = PW'(left_nxt);

`ifdef ASSOC_TIE_HOLD_EN
    logic [CW-1:0] tie_cnt, tie_nxt;
    logic [PW-1:0] tie_p;

    assign tie_nxt = tie_cnt + CW'(tie);
    assign tie_p   = PW'(tie_nxt);
    assign hold    = (tie_p << 1) >= EL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tie_cnt <= '0;
        end else if (complete) begin
            tie_cnt <= epoch_end ? '0 : tie_nxt;
        end
    end
`else
    logic unused_tie;

    assign unused_tie = tie;
    assign hold       = 1'b0;
`endif

    always_comb begin
        desired = 2'd3;
        if ((conf_p << 4) < EL) begin
            desired = 2'd0;
        end else if ((conf_p << 3) < EL) begin
            desired = 2'd1;
        end else if ((conf_p << 2) < EL) begin
            desired = 2'd2;
        end
        // Strongly skewed PLRU root means one half dominates: lean wider.
        if (((left_p << 2) > EL3 || (left_p << 2) < EL) && desired != 2'd3) begin
            desired = desired + 2'd1;
        end
    end

    assoc_tag_history #(
        .SET_BITS (SET_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .clear     (handshake),
        .set_index (acc_set),
        .tag       (acc_tag),
        .wr_en     (complete),
        .conflict  (conflict)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt  <= '0;
            conf_cnt <= '0;
            left_cnt <= '0;
        end else if (complete) begin
            if (epoch_end) begin
                acc_cnt  <= '0;
                conf_cnt <= '0;
                left_cnt <= '0;
            end else begin
                acc_cnt  <= acc_cnt + 1'b1;
                conf_cnt <= conf_nxt;
                left_cnt <= left_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setup_valid  <= 1'b0;
            setup_update <= 2'd0;
        end else if (handshake) begin
            setup_valid  <= 1'b0;
            setup_update <= 2'd0;
        end else if (epoch_end && desired != setup && !hold) begin
            setup_valid  <= 1'b1;
            setup_update <= step_toward(setup, desired);
        end
    end

endmodule

// File: tb/tb_assoc_mode_advisor.sv
// Self-checking bench for assoc_mode_advisor with EPOCH_LEN=16.
// Scenario tasks plus a randomized run against an epoch-level reference model.
module tb_assoc_mode_advisor;
    import mutative_types::*;

    localparam int E = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    cache_address_t cache_address = '0;
    logic           cpu_request = 1'b0;
    logic           cache_ready = 1'b0;
    logic [1:0]     setup = 2'd0;
    logic           plru_bit0 = 1'b0;
    logic           tie = 1'b0;
    logic           setup_ready = 1'b0;
    logic           setup_valid;
    logic [1:0]     setup_update;

    int checks = 0;
    int errors = 0;

    bit m_valid;
    int m_update, m_acc, m_conf, m_left, m_tie;
    bit hv [16];
    int ht [16];

    assoc_mode_advisor #(.EPOCH_LEN(E)) dut (
        .clk           (clk),
        .rst           (rst),
        .cache_address (cache_address),
        .cpu_request   (cpu_request),
        .cache_ready   (cache_ready),
        .setup         (setup),
        .plru_bit0     (plru_bit0),
        .tie           (tie),
        .setup_ready   (setup_ready),
        .setup_valid   (setup_valid),
        .setup_update  (setup_update)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int tag, input int set);
        logic [31:0] a;
        a = (32'(tag) << 9) | (32'(set & 15) << 5) | 32'($urandom_range(0, 31));
        return a;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_update = 0;
        m_acc = 0; m_conf = 0; m_left = 0; m_tie = 0;
        for (int i = 0; i < 16; i++) begin
            hv[i] = 0; ht[i] = 0;
        end
    endtask

    // Mode wanted for an epoch, straight from the conflict/bias rules.
    function automatic int want_mode(input int conf, input int left);
        int w;
        if (conf * 16 < E) w = 0;
        else if (conf * 8 < E) w = 1;
        else if (conf * 4 < E) w = 2;
        else w = 3;
        if (left * 4 > 3 * E || left * 4 < E) w = (w == 3) ? 3 : w + 1;
        return w;
    endfunction

    // Advance the model by one clock with the currently driven inputs, then clock.
    task automatic tick();
        bit hs, done, held;
        int s, t, w;
        hs   = m_valid && setup_ready;
        done = cpu_request && cache_ready && !m_valid;
        if (hs) begin
            m_valid = 0; m_update = 0;
            for (int i = 0; i < 16; i++) hv[i] = 0;
        end
        if (done) begin
            s = int'(cache_address) >>> 5 & 15;
            t = int'(unsigned'(cache_address) >> 9);
            if (hv[s] && ht[s] != t) m_conf++;
            hv[s] = 1; ht[s] = t;
            m_acc++;
            m_left += plru_bit0;
            m_tie += tie;
            if (m_acc == E) begin
                w = want_mode(m_conf, m_left);
`ifdef ASSOC_TIE_HOLD_EN
                held = (m_tie * 2 >= E);
`else
                held = 0;
`endif
                if (!held && w != int'(setup)) begin
                    m_valid = 1;
                    m_update = (w > int'(setup)) ? int'(setup) + 1 : int'(setup) - 1;
                end
                m_acc = 0; m_conf = 0; m_left = 0; m_tie = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int tag, input int set, input bit plru, input bit t);
        cpu_request   = 1'b1;
        cache_ready   = 1'b1;
        cache_address = mk(tag, set);
        plru_bit0     = plru;
        tie           = t;
        tick();
    endtask

    task automatic do_handshake(input string name);
        cpu_request = 1'b0;
        setup_ready = 1'b1;
        tick();
        setup_ready = 1'b0;
        checks++;
        if (setup_valid !== 1'b0 || setup_update !== 2'd0) begin
            errors++;
            $display("FAIL %s handshake: valid=%0b update=%0d expected 0/0",
                     name, setup_valid, setup_update);
        end
    endtask

    task automatic async_reset(input string name);
        cpu_request = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (setup_valid !== 1'b0 || setup_update !== 2'd0) begin
            errors++;
            $display("FAIL %s async reset: valid=%0b update=%0d expected 0/0",
                     name, setup_valid, setup_update);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if (setup_valid !== 1'b0 || setup_update !== 2'd0) begin
            errors++;
            $display("FAIL reset: valid=%0b update=%0d expected 0/0",
                     setup_valid, setup_update);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_step_down();
        setup = 2'd3;
        for (int i = 0; i < E; i++) begin
            access(7, 2, i[0], 1'b0);
            checks++;
            if (setup_valid !== (i == E - 1)) begin
                errors++;
                $display("FAIL step_down valid@%0d: got %0b expected %0b",
                         i, setup_valid, (i == E - 1));
            end
        end
        checks++;
        if (setup_update !== 2'd2) begin
            errors++;
            $display("FAIL step_down update: got %0d expected 2", setup_update);
        end
        do_handshake("step_down");
    endtask

    task automatic test_step_up_and_stall();
        setup = 2'd0;
        for (int i = 0; i < E; i++) access(1 + (i % 2), 5, 1'b0, 1'b0);
        checks++;
        if (setup_valid !== 1'b1 || setup_update !== 2'd1) begin
            errors++;
            $display("FAIL step_up: valid=%0b update=%0d expected 1/1",
                     setup_valid, setup_update);
        end
        setup_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            access(int'($urandom_range(0, 7)), i, 1'b1, 1'b0);
            checks++;
            if (setup_valid !== 1'b1 || setup_update !== 2'd1) begin
                errors++;
                $display("FAIL stall hold@%0d: valid=%0b update=%0d expected 1/1",
                         i, setup_valid, setup_update);
            end
        end
        do_handshake("stall");
        setup = 2'd3;
        for (int i = 0; i < E; i++) begin
            access(3, 5, i[0], 1'b0);
            checks++;
            if (setup_valid !== (i == E - 1)) begin
                errors++;
                $display("FAIL stall fresh epoch valid@%0d: got %0b expected %0b",
                         i, setup_valid, (i == E - 1));
            end
        end
        checks++;
        if (setup_update !== 2'd2) begin
            errors++;
            $display("FAIL stall fresh update: got %0d expected 2", setup_update);
        end
        do_handshake("stall2");
    endtask

    task automatic test_bias();
        setup = 2'd2;
        for (int i = 0; i < E; i++) begin
            access((i == 0) ? 10 : 11, 1, 1'b1, 1'b0);
            checks++;
            if (setup_valid !== 1'b0) begin
                errors++;
                $display("FAIL bias cancel valid@%0d: got %0b expected 0", i, setup_valid);
            end
        end
        setup = 2'd0;
        for (int i = 0; i < E; i++) begin
            access(11, 1, 1'b0, 1'b0);
            checks++;
            if (setup_valid !== (i == E - 1)) begin
                errors++;
                $display("FAIL bias counters cleared valid@%0d: got %0b expected %0b",
                         i, setup_valid, (i == E - 1));
            end
        end
        checks++;
        if (setup_update !== 2'd1) begin
            errors++;
            $display("FAIL bias next update: got %0d expected 1", setup_update);
        end
        do_handshake("bias");
    endtask

    task automatic test_reset_mid_epoch();
        setup = 2'd3;
        for (int i = 0; i < E; i++) access(4, 9, i[0], 1'b0);
        checks++;
        if (setup_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre-reset pending: got %0b expected 1", setup_valid);
        end
        async_reset("pending");
        setup = 2'd0;
        for (int i = 0; i < 10; i++) access(4, 9, 1'b0, 1'b0);
        async_reset("mid_epoch");
        for (int i = 0; i < E; i++) begin
            access(4, 9, 1'b0, 1'b0);
            checks++;
            if (setup_valid !== (i == E - 1)) begin
                errors++;
                $display("FAIL post-reset epoch valid@%0d: got %0b expected %0b",
                         i, setup_valid, (i == E - 1));
            end
        end
        checks++;
        if (setup_update !== 2'd1) begin
            errors++;
            $display("FAIL post-reset update: got %0d expected 1", setup_update);
        end
        do_handshake("reset_mid");
    endtask

    task automatic test_tie();
        bit exp_v;
        logic [1:0] exp_u;
`ifdef ASSOC_TIE_HOLD_EN
        exp_v = 1'b0; exp_u = 2'd0;
`else
        exp_v = 1'b1; exp_u = 2'd2;
`endif
        setup = 2'd3;
        for (int i = 0; i < E; i++) access(6, 3, i[0], i < 8);
        checks++;
        if (setup_valid !== exp_v || setup_update !== exp_u) begin
            errors++;
            $display("FAIL tie: valid=%0b update=%0d expected %0b/%0d",
                     setup_valid, setup_update, exp_v, exp_u);
        end
        if (exp_v) do_handshake("tie");
    endtask

    task automatic test_random();
        async_reset("random");
        for (int c = 0; c < 1500; c++) begin
            cpu_request   = ($urandom_range(0, 3) != 0);
            cache_ready   = ($urandom_range(0, 3) != 0);
            cache_address = mk(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            plru_bit0     = ($urandom_range(0, 4) == 0);
            tie           = ($urandom_range(0, 1) == 0);
            setup_ready   = ($urandom_range(0, 3) == 0);
            setup         = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (setup_valid !== m_valid || int'(setup_update) != m_update) begin
                errors++;
                $display("FAIL random@%0d: valid=%0b update=%0d expected %0b/%0d",
                         c, setup_valid, setup_update, m_valid, m_update);
            end
        end
        cpu_request = 1'b0;
        setup_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step_down();
        test_step_up_and_stall();
        test_bias();
        test_reset_mid_epoch();
        async_reset("tie");
        test_tie();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
